// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per accepted i_Tx_Dv, 10*CLKS_PER_BIT cycles from accept to Done pulse.
// No backpressure or queuing: requests are only taken in IDLE, anything arriving mid-frame is dropped.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Tx_Dv,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       byte_q;
    logic             serial_q;
    logic             active_q;
    logic             done_q;

    // Serial output is loaded one edge ahead, so each line level lands in the cycle it belongs to.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    serial_q  <= 1'b1;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    done_q    <= 1'b0;
                    active_q  <= 1'b0;
                    if (i_Tx_Dv) begin
                        byte_q   <= i_Tx_Byte;
                        active_q <= 1'b1;
                        serial_q <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == CNT_MAX) begin
                        clk_cnt_q <= '0;
                        serial_q  <= byte_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == CNT_MAX) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q < 3'd7) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= byte_q[bit_idx_q + 3'd1];
                        end else begin
                            bit_idx_q <= '0;
                            serial_q  <= 1'b1;
                            state_q   <= S_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    serial_q <= 1'b1;
                    if (clk_cnt_q == CNT_MAX) begin
                        clk_cnt_q <= '0;
                        done_q    <= 1'b1;
                        active_q  <= 1'b0;
                        state_q   <= S_CLEANUP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    serial_q <= 1'b1;
                    done_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    serial_q  <= 1'b1;
                    active_q  <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule
